typed_sync_fifo: RTL

TYPED_SYNC_FIFO -- requirements
Module: typed_sync_fifo

---
 rtl/typed_sync_fifo.sv | 77 +++++++
 1 files changed

// File: rtl/typed_sync_fifo.sv
// Synchronous FIFO carrying an arbitrary payload type, registered outputs only.
// Occupancy count drives ready/valid so neither depends on the opposite port.
module typed_sync_fifo #(
    parameter type data_t = logic [8:0],
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  data_t            in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output data_t            out_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o
);

    localparam int AW = $clog2(DEPTH);

    data_t            mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push, pop;

    assign in_ready_o  = (count_q != CNT_W'(DEPTH));
    assign out_valid_o = (count_q != '0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop) count_d = count_q + CNT_W'(1);
            if (!push && pop) count_d = count_q - CNT_W'(1);
            if (in_valid_i && !in_ready_o) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is never reset; a flushed or reset cycle must not write.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i && !rst_i) mem_q[wr_ptr_q] <= in_data_i;
    end

endmodule
